// File: rtl/xeng_pkg.sv
// Shared definitions for the X-engine window controller: state encoding,
// default parameter values and the derived-width helper functions.
package xeng_pkg;

    localparam int DEF_N_ANTS              = 10;
    localparam int DEF_SERIAL_ACC_LEN_BITS = 6;
    localparam int DEF_MCNT_WIDTH          = 48;
    localparam int DEF_MCNT_STEP           = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } win_state_t;

    // Ceiling log2 built from a bounded loop so it elaborates everywhere.
    function automatic int clog2_f(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

    // A single antenna still needs a one-bit slot field.
    function automatic int ant_bits_f(input int n_ants);
        return (clog2_f(n_ants) < 1) ? 1 : clog2_f(n_ants);
    endfunction

    function automatic int win_len_f(input int n_ants, input int samp_bits);
        return n_ants * (1 << samp_bits);
    endfunction

endpackage

// File: rtl/xeng_slot_ctr.sv
// Two-level sample/antenna-slot counter with clear, enable and
// terminal-count flags for both the current and the next count value.
module xeng_slot_ctr
    import xeng_pkg::*;
#(
    parameter int N_ANTS    = DEF_N_ANTS,
    parameter int SAMP_BITS = DEF_SERIAL_ACC_LEN_BITS,
    parameter int ANT_BITS  = ant_bits_f(DEF_N_ANTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    output logic [SAMP_BITS-1:0] samp_idx_o,
    output logic [ANT_BITS-1:0]  ant_slot_o,
    output logic                 tc_o,
    output logic                 tc_next_o
);

    localparam logic [SAMP_BITS-1:0] SAMP_MAX = '1;
    localparam logic [ANT_BITS-1:0]  ANT_MAX  = ANT_BITS'(N_ANTS - 1);

    logic [SAMP_BITS-1:0] samp_q, samp_d;
    logic [ANT_BITS-1:0]  ant_q,  ant_d;

    // Counting past the terminal value wraps to slot 0, sample 0, which is
    // exactly the first index of a back-to-back window.
    always_comb begin
        samp_d = samp_q;
        ant_d  = ant_q;
        if (clr_i) begin
            samp_d = '0;
            ant_d  = '0;
        end else if (en_i) begin
            if (samp_q == SAMP_MAX) begin
                samp_d = '0;
                ant_d  = (ant_q == ANT_MAX) ? '0 : ant_q + 1'b1;
            end else begin
                samp_d = samp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_q <= '0;
            ant_q  <= '0;
        end else begin
            samp_q <= samp_d;
            ant_q  <= ant_d;
        end
    end

    assign samp_idx_o = samp_q;
    assign ant_slot_o = ant_q;
    assign tc_o       = (samp_q == SAMP_MAX) && (ant_q == ANT_MAX);
    assign tc_next_o  = (samp_d == SAMP_MAX) && (ant_d == ANT_MAX);

endmodule

// File: rtl/xeng_win_ctrl.sv
// X-engine window controller: frames the sample stream into fixed-length
// windows. Define XENG_WIN_CTRL_MCNT_CHECK_EN to build the mcnt continuity check.
module xeng_win_ctrl
    import xeng_pkg::*;
#(
    parameter int N_ANTS              = DEF_N_ANTS,
    parameter int SERIAL_ACC_LEN_BITS = DEF_SERIAL_ACC_LEN_BITS,
    parameter int MCNT_WIDTH          = DEF_MCNT_WIDTH,
    parameter int MCNT_STEP           = DEF_MCNT_STEP,
    localparam int ANT_BITS           = ant_bits_f(N_ANTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ce,
    input  logic                           sync_in,
    input  logic                           vld_in,
    input  logic [MCNT_WIDTH-1:0]          mcnt_in,
    output logic                           sync_out,
    output logic [ANT_BITS-1:0]            ant_slot,
    output logic [SERIAL_ACC_LEN_BITS-1:0] samp_idx,
    output logic                           win_start,
    output logic                           win_last,
    output logic                           win_done,
    output logic [MCNT_WIDTH-1:0]          win_mcnt,
    output logic [15:0]                    win_count,
    output logic                           err_gap,
    output logic                           err_sync,
    output logic                           err_mcnt,
    output logic                           busy
);

    win_state_t state_q, state_d;

    logic                  sync_out_q, win_start_q, win_last_q;
    logic                  err_gap_q, err_sync_q, busy_q;
    logic [MCNT_WIDTH-1:0] win_mcnt_q;
    logic [15:0]           win_count_q;

    logic cnt_clr, cnt_en, cnt_tc, cnt_tc_next;
    logic start_d, last_d, gap_d, esync_d, chain_clr;

    logic unused_ce;
    assign unused_ce = ce;

    xeng_slot_ctr #(
        .N_ANTS    (N_ANTS),
        .SAMP_BITS (SERIAL_ACC_LEN_BITS),
        .ANT_BITS  (ANT_BITS)
    ) u_slot_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .samp_idx_o (samp_idx),
        .ant_slot_o (ant_slot),
        .tc_o       (cnt_tc),
        .tc_next_o  (cnt_tc_next)
    );

    // Sync has priority over everything; in RUN a held terminal count means
    // the previous window finished, so a missing vld is not a gap.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        start_d = 1'b0;
        gap_d   = 1'b0;
        esync_d = 1'b0;
        if (sync_in) begin
            state_d = ST_ARMED;
            cnt_clr = 1'b1;
            esync_d = (state_q == ST_RUN);
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (vld_in) begin
                        state_d = ST_RUN;
                        cnt_clr = 1'b1;
                        start_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (vld_in) begin
                        cnt_en  = 1'b1;
                        start_d = cnt_tc;
                    end else begin
                        state_d = ST_ARMED;
                        gap_d   = !cnt_tc;
                    end
                end
                default: ;
            endcase
        end
        last_d    = (start_d | cnt_en) & cnt_tc_next;
        chain_clr = sync_in | gap_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sync_out_q  <= 1'b0;
            win_start_q <= 1'b0;
            win_last_q  <= 1'b0;
            err_gap_q   <= 1'b0;
            err_sync_q  <= 1'b0;
            busy_q      <= 1'b0;
            win_mcnt_q  <= '0;
            win_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sync_out_q  <= sync_in;
            win_start_q <= start_d;
            win_last_q  <= last_d;
            err_gap_q   <= gap_d;
            err_sync_q  <= esync_d;
            busy_q      <= (state_d == ST_RUN);
            if (start_d) begin
                win_mcnt_q <= mcnt_in;
            end
            if (last_d) begin
                win_count_q <= win_count_q + 16'd1;
            end
        end
    end

`ifdef XENG_WIN_CTRL_MCNT_CHECK_EN
    // have_prev_q marks that the last window completed cleanly, so the next
    // start may be compared against its timestamp.
    logic have_prev_q;
    logic err_mcnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            have_prev_q <= 1'b0;
            err_mcnt_q  <= 1'b0;
        end else begin
            if (chain_clr) begin
                have_prev_q <= 1'b0;
            end else if (last_d) begin
                have_prev_q <= 1'b1;
            end
            err_mcnt_q <= start_d && have_prev_q &&
                          (mcnt_in != win_mcnt_q + MCNT_WIDTH'(MCNT_STEP));
        end
    end

    assign err_mcnt = err_mcnt_q;
`else
    logic unused_chain_clr;
    assign unused_chain_clr = chain_clr;
    assign err_mcnt = 1'b0;
`endif

    assign sync_out  = sync_out_q;
    assign win_start = win_start_q;
    assign win_last  = win_last_q;
    assign win_done  = win_last_q;
    assign win_mcnt  = win_mcnt_q;
    assign win_count = win_count_q;
    assign err_gap   = err_gap_q;
    assign err_sync  = err_sync_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_xeng_win_ctrl.sv
// Self-checking bench for xeng_win_ctrl: directed scenarios plus a randomized
// run compared against a window-position reference model.
module tb_xeng_win_ctrl;

    localparam int N_ANTS  = 10;
    localparam int SB      = 6;
    localparam int MW      = 48;
    localparam int SLOT    = 1 << SB;
    localparam int WIN_LEN = N_ANTS * SLOT;
`ifdef XENG_WIN_CTRL_MCNT_CHECK_EN
    localparam bit MCNT_CHK = 1'b1;
`else
    localparam bit MCNT_CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, ce, sync_in, vld_in;
    logic [MW-1:0] mcnt_in;
    logic          sync_out, win_start, win_last, win_done;
    logic [3:0]    ant_slot;
    logic [SB-1:0] samp_idx;
    logic [MW-1:0] win_mcnt;
    logic [15:0]   win_count;
    logic          err_gap, err_sync, err_mcnt, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xeng_win_ctrl #(
        .N_ANTS              (N_ANTS),
        .SERIAL_ACC_LEN_BITS (SB),
        .MCNT_WIDTH          (MW),
        .MCNT_STEP           (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .sync_in   (sync_in),
        .vld_in    (vld_in),
        .mcnt_in   (mcnt_in),
        .sync_out  (sync_out),
        .ant_slot  (ant_slot),
        .samp_idx  (samp_idx),
        .win_start (win_start),
        .win_last  (win_last),
        .win_done  (win_done),
        .win_mcnt  (win_mcnt),
        .win_count (win_count),
        .err_gap   (err_gap),
        .err_sync  (err_sync),
        .err_mcnt  (err_mcnt),
        .busy      (busy)
    );

    // Reference model: position of the current sample within its window.
    bit            m_synced, m_running, m_chain;
    int            m_pos;
    logic          e_sync_out, e_start, e_last, e_gap, e_esync, e_emcnt, e_busy;
    logic [3:0]    e_ant;
    logic [SB-1:0] e_samp;
    logic [MW-1:0] e_mcnt;
    logic [15:0]   e_count;

    function automatic void model_step(input logic r, input logic s, input logic v,
                                       input logic [MW-1:0] m);
        e_start = 1'b0; e_last = 1'b0; e_gap = 1'b0; e_esync = 1'b0; e_emcnt = 1'b0;
        if (!r) begin
            m_synced = 0; m_running = 0; m_chain = 0; m_pos = 0;
            e_sync_out = 1'b0; e_ant = '0; e_samp = '0; e_mcnt = '0; e_count = '0;
            e_busy = 1'b0;
            return;
        end
        e_sync_out = s;
        if (s) begin
            e_esync   = m_running;
            m_running = 0; m_synced = 1; m_chain = 0;
            e_ant = '0; e_samp = '0;
        end else if (m_running && !v) begin
            if (m_pos != WIN_LEN - 1) begin
                e_gap   = 1'b1;
                m_chain = 0;
            end
            m_running = 0;
        end else if (v && m_synced) begin
            if (!m_running || m_pos == WIN_LEN - 1) begin
                m_pos = 0; m_running = 1; e_start = 1'b1;
                if (MCNT_CHK && m_chain && (m != e_mcnt + 48'd1)) e_emcnt = 1'b1;
                e_mcnt = m;
            end else begin
                m_pos++;
            end
            e_ant  = 4'(m_pos / SLOT);
            e_samp = SB'(m_pos % SLOT);
            if (m_pos == WIN_LEN - 1) begin
                e_last  = 1'b1;
                e_count = e_count + 16'd1;
                m_chain = 1;
            end
        end
        e_busy = m_running;
    endfunction

    task automatic tick(input logic r, input logic s, input logic v, input logic [MW-1:0] m);
        rst_n = r; sync_in = s; vld_in = v; mcnt_in = m; ce = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        model_step(r, s, v, m);
    endtask

    task automatic run_samples(input int n, input logic [MW-1:0] m);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b1, m);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b1, 48'd5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sync_out !== 1'b0) begin errors++; $display("FAIL reset_sync_out got %b want 0", sync_out); end
        checks++; if ({ant_slot, samp_idx} !== 10'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", ant_slot, samp_idx); end
        checks++; if (win_count !== 16'd0 || win_mcnt !== '0) begin errors++; $display("FAIL reset_win_regs got %0d/%0d want 0/0", win_count, win_mcnt); end
        checks++; if ({win_start, win_last, win_done, err_gap, err_sync, err_mcnt} !== 6'd0) begin errors++; $display("FAIL reset_pulses got %b want 000000", {win_start, win_last, win_done, err_gap, err_sync, err_mcnt}); end
        tick(1'b1, 1'b0, 1'b1, 48'd5);
        checks++; if (busy !== 1'b0 || win_start !== 1'b0) begin errors++; $display("FAIL idle_ignores_vld got busy=%b start=%b want 0 0", busy, win_start); end
    endtask

    task automatic test_nominal();
        tick(1'b1, 1'b1, 1'b0, 48'd7);
        checks++; if (sync_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL nom_sync got sync_out=%b busy=%b want 1 0", sync_out, busy); end
        tick(1'b1, 1'b0, 1'b1, 48'd7);
        checks++; if (win_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL nom_start got start=%b busy=%b want 1 1", win_start, busy); end
        checks++; if (win_mcnt !== 48'd7 || ant_slot !== 4'd0 || samp_idx !== 6'd0) begin errors++; $display("FAIL nom_first got mcnt=%0d ant=%0d samp=%0d want 7 0 0", win_mcnt, ant_slot, samp_idx); end
        tick(1'b1, 1'b0, 1'b1, 48'd7);
        checks++; if (win_start !== 1'b0 || samp_idx !== 6'd1 || sync_out !== 1'b0) begin errors++; $display("FAIL nom_second got start=%b samp=%0d sync_out=%b want 0 1 0", win_start, samp_idx, sync_out); end
        run_samples(SLOT - 2, 48'd7);
        tick(1'b1, 1'b0, 1'b1, 48'd7);
        checks++; if (ant_slot !== 4'd1 || samp_idx !== 6'd0) begin errors++; $display("FAIL nom_slot_wrap got ant=%0d samp=%0d want 1 0", ant_slot, samp_idx); end
        run_samples(WIN_LEN - SLOT - 2, 48'd7);
        checks++; if (win_last !== 1'b0 || win_count !== 16'd0) begin errors++; $display("FAIL nom_before_last got last=%b count=%0d want 0 0", win_last, win_count); end
        tick(1'b1, 1'b0, 1'b1, 48'd7);
        checks++; if (win_last !== 1'b1 || win_done !== 1'b1 || win_count !== 16'd1) begin errors++; $display("FAIL nom_last got last=%b done=%b count=%0d want 1 1 1", win_last, win_done, win_count); end
        checks++; if (ant_slot !== 4'd9 || samp_idx !== 6'd63) begin errors++; $display("FAIL nom_last_idx got ant=%0d samp=%0d want 9 63", ant_slot, samp_idx); end
        tick(1'b1, 1'b0, 1'b1, 48'd8);
        checks++; if (win_start !== 1'b1 || win_last !== 1'b0 || {ant_slot, samp_idx} !== 10'd0) begin errors++; $display("FAIL nom_b2b got start=%b last=%b ant=%0d samp=%0d want 1 0 0 0", win_start, win_last, ant_slot, samp_idx); end
        checks++; if (win_mcnt !== 48'd8 || err_mcnt !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL nom_b2b_mcnt got mcnt=%0d err=%b busy=%b want 8 0 1", win_mcnt, err_mcnt, busy); end
    endtask

    task automatic test_gap();
        logic [15:0] cnt0;
        tick(1'b1, 1'b1, 1'b0, 48'd20);
        cnt0 = win_count;
        run_samples(300, 48'd20);
        tick(1'b1, 1'b0, 1'b0, 48'd20);
        checks++; if (err_gap !== 1'b1 || win_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL gap_pulse got gap=%b done=%b busy=%b want 1 0 0", err_gap, win_done, busy); end
        checks++; if (win_count !== cnt0 || ant_slot !== 4'd4 || samp_idx !== 6'd43) begin errors++; $display("FAIL gap_hold got count=%0d ant=%0d samp=%0d want %0d 4 43", win_count, ant_slot, samp_idx, cnt0); end
        tick(1'b1, 1'b0, 1'b0, 48'd20);
        checks++; if (err_gap !== 1'b0) begin errors++; $display("FAIL gap_single got %b want 0", err_gap); end
        tick(1'b1, 1'b0, 1'b1, 48'd21);
        checks++; if (win_start !== 1'b1 || {ant_slot, samp_idx} !== 10'd0 || err_mcnt !== 1'b0) begin errors++; $display("FAIL gap_restart got start=%b ant=%0d samp=%0d errm=%b want 1 0 0 0", win_start, ant_slot, samp_idx, err_mcnt); end
    endtask

    task automatic test_sync_mid();
        tick(1'b1, 1'b1, 1'b0, 48'd30);
        run_samples(500, 48'd30);
        tick(1'b1, 1'b1, 1'b1, 48'd30);
        checks++; if (sync_out !== 1'b1 || err_sync !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL syncmid_pulse got sync_out=%b err=%b busy=%b want 1 1 0", sync_out, err_sync, busy); end
        checks++; if ({ant_slot, samp_idx} !== 10'd0 || win_start !== 1'b0 || err_gap !== 1'b0) begin errors++; $display("FAIL syncmid_clear got ant=%0d samp=%0d start=%b gap=%b want 0 0 0 0", ant_slot, samp_idx, win_start, err_gap); end
        tick(1'b1, 1'b0, 1'b0, 48'd30);
        checks++; if (err_sync !== 1'b0 || sync_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL syncmid_armed got err=%b sync_out=%b busy=%b want 0 0 0", err_sync, sync_out, busy); end
    endtask

    task automatic test_sync_vld();
        tick(1'b1, 1'b1, 1'b1, 48'd40);
        checks++; if (win_start !== 1'b0 || busy !== 1'b0 || err_sync !== 1'b0) begin errors++; $display("FAIL syncvld_ignored got start=%b busy=%b err=%b want 0 0 0", win_start, busy, err_sync); end
        tick(1'b1, 1'b0, 1'b1, 48'd40);
        checks++; if (win_start !== 1'b1 || samp_idx !== 6'd0 || win_mcnt !== 48'd40) begin errors++; $display("FAIL syncvld_start got start=%b samp=%0d mcnt=%0d want 1 0 40", win_start, samp_idx, win_mcnt); end
    endtask

    task automatic test_mcnt();
        tick(1'b1, 1'b1, 1'b0, 48'd0);
        tick(1'b1, 1'b0, 1'b1, 48'd0);
        checks++; if (win_start !== 1'b1 || err_mcnt !== 1'b0) begin errors++; $display("FAIL mcnt_first got start=%b err=%b want 1 0", win_start, err_mcnt); end
        run_samples(WIN_LEN - 1, 48'd0);
        tick(1'b1, 1'b0, 1'b0, 48'd0);
        checks++; if (err_gap !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mcnt_end_armed got gap=%b busy=%b want 0 0", err_gap, busy); end
        tick(1'b1, 1'b0, 1'b1, 48'd2);
        checks++; if (win_start !== 1'b1 || err_mcnt !== MCNT_CHK) begin errors++; $display("FAIL mcnt_jump got start=%b err=%b want 1 %b", win_start, err_mcnt, MCNT_CHK); end
        tick(1'b1, 1'b0, 1'b1, 48'd2);
        checks++; if (err_mcnt !== 1'b0) begin errors++; $display("FAIL mcnt_single got %b want 0", err_mcnt); end
        run_samples(WIN_LEN - 2, 48'd2);
        tick(1'b1, 1'b0, 1'b1, 48'd3);
        checks++; if (win_start !== 1'b1 || err_mcnt !== 1'b0 || win_mcnt !== 48'd3) begin errors++; $display("FAIL mcnt_ok got start=%b err=%b mcnt=%0d want 1 0 3", win_start, err_mcnt, win_mcnt); end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b1, 1'b0, 48'd50);
        run_samples(320, 48'd50);
        tick(1'b0, 1'b0, 1'b1, 48'd50);
        checks++; if ({sync_out, ant_slot, samp_idx, win_start, win_last, win_done, win_mcnt, win_count, err_gap, err_sync, err_mcnt, busy} !== '0) begin errors++; $display("FAIL rstmid_zero got cnt=%0d mcnt=%0d ant=%0d samp=%0d busy=%b", win_count, win_mcnt, ant_slot, samp_idx, busy); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b1, 48'd51);
            checks++; if (busy !== 1'b0 || win_start !== 1'b0 || err_gap !== 1'b0) begin errors++; $display("FAIL rstmid_idle got busy=%b start=%b gap=%b want 0 0 0", busy, win_start, err_gap); end
        end
    endtask

    task automatic test_random();
        logic          r, s, v;
        logic [MW-1:0] m;
        logic [81:0]   act, exp_v;
        tick(1'b1, 1'b1, 1'b0, '0);
        for (int cyc = 0; cyc < 8000; cyc++) begin
            r = ($urandom_range(0, 4999) != 0);
            s = ($urandom_range(0, 2999) == 0);
            v = ($urandom_range(0, 2999) != 0);
            if ($urandom_range(0, 499) == 0) v = 1'b0;
            m = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : e_mcnt + 48'd1;
            if (!m_synced && $urandom_range(0, 49) == 0) s = 1'b1;
            tick(r, s, v, m);
            act   = {sync_out, ant_slot, samp_idx, win_start, win_last, win_done,
                     win_mcnt, win_count, err_gap, err_sync, err_mcnt, busy};
            exp_v = {e_sync_out, e_ant, e_samp, e_start, e_last, e_last,
                     e_mcnt, e_count, e_gap, e_esync, e_emcnt, e_busy};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d got %h want %h", cyc, act, exp_v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; sync_in = 1'b0; vld_in = 1'b0; mcnt_in = '0;
        test_reset();
        test_nominal();
        test_gap();
        test_sync_mid();
        test_sync_vld();
        test_mcnt();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
